// File: rtl/cmos_gen_pkg.sv
// cmos_gen_pkg: shared FSM/mode types, colour-bar palette and frame-length helper
package cmos_gen_pkg;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, HBLANK, ACTIVE, VFRONT} state_t;
    typedef enum logic [1:0] {MODE_CNT, MODE_BARS, MODE_CONST, MODE_GRAD} mode_t;
    // index 0 is the leftmost bar
    localparam logic [7:0][15:0] BAR_RGB = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                            16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
    function automatic int frame_len(input int vs, input int vb, input int va, input int hb,
                                     input int ha, input int bpp, input int vf);
        return vs + vb + va * (hb + ha * bpp) + vf;
    endfunction
endpackage

// File: rtl/cmos_pix_src.sv
// cmos_pix_src: pixel pattern generator and byte serialiser with registered data output
module cmos_pix_src
    import cmos_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int BPP      = 2,
    parameter int CNT_WRAP = 799
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        clr,
    input  logic        act,
    input  logic        phase,
    input  logic        adv,
    input  logic [1:0]  mode,
    input  logic [15:0] const_pix,
    input  logic [15:0] frame_cnt,
    output logic [7:0]  data
);
    localparam logic [15:0] WRAP = 16'(CNT_WRAP);
    localparam logic [15:0] XMAX = 16'(H_ACTIVE - 1);
    localparam logic [15:0] SMAX = 16'(H_ACTIVE / 8 - 1);
    mode_t       mode_q;
    logic [15:0] cpix_q, fc_q, cnt, x, sub, p;
    logic [2:0]  bar;
    logic [7:0]  byte_n;
    always_comb begin
        p = mode_q == MODE_CNT   ? cnt :
            mode_q == MODE_BARS  ? BAR_RGB[bar] :
            mode_q == MODE_CONST ? cpix_q : x + fc_q;
        byte_n = (BPP == 2 && !phase) ? p[15:8] : p[7:0];
    end
    // counters always hold the next pixel to emit; they step after its last byte is loaded
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mode_q <= MODE_CNT;
            cpix_q <= '0;
            fc_q   <= '0;
            cnt    <= '0;
            x      <= '0;
            sub    <= '0;
            bar    <= '0;
            data   <= '0;
        end else begin
            if (clr) begin
                mode_q <= mode_t'(mode);
                cpix_q <= const_pix;
                fc_q   <= frame_cnt;
                cnt    <= '0;
                x      <= '0;
                sub    <= '0;
                bar    <= '0;
            end else if (adv) begin
                cnt <= cnt == WRAP ? '0 : cnt + 16'd1;
                x   <= x == XMAX ? '0 : x + 16'd1;
                sub <= sub == SMAX ? '0 : sub + 16'd1;
                if (sub == SMAX) bar <= bar + 3'd1;
            end
            data <= act ? byte_n : 8'd0;
        end
    end
endmodule

// File: rtl/cmos_frame_gen.sv
// cmos_frame_gen: DVP/CMOS-style test frame source with programmable geometry and pattern
module cmos_frame_gen
    import cmos_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 100,
    parameter int VS_LEN   = 1001,
    parameter int V_BACK   = 16,
    parameter int V_FRONT  = 16,
    parameter int BPP      = 2,
    parameter int CNT_WRAP = 799
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        run,
    input  logic [1:0]  mode,
    input  logic [15:0] const_pix,
    output logic        cmos_vsyn,
    output logic        cmos_href,
    output logic [7:0]  cmos_data,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam logic [15:0] L_VS   = 16'(VS_LEN - 1);
    localparam logic [15:0] L_VB   = 16'(V_BACK - 1);
    localparam logic [15:0] L_HB   = 16'(H_BLANK - 1);
    localparam logic [15:0] L_ACT  = 16'(H_ACTIVE * BPP - 1);
    localparam logic [15:0] L_VF   = 16'(V_FRONT - 1);
    localparam logic [15:0] L_LINE = 16'(V_ACTIVE - 1);
    state_t      state, state_n;
    logic [15:0] tcnt, tcnt_n, line, line_n, dur;
    logic        last, start, act, phase, adv;
    // everything is decided from the next state so outputs come straight from flops
    always_comb begin
        dur = state == VSYNC  ? L_VS :
              state == VBACK  ? L_VB :
              state == HBLANK ? L_HB :
              state == ACTIVE ? L_ACT : L_VF;
        last    = tcnt == dur;
        state_n = state;
        tcnt_n  = last ? 16'd0 : tcnt + 16'd1;
        line_n  = line;
        start   = 1'b0;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (run) begin
                    state_n = VSYNC;
                    start   = 1'b1;
                end
            end
            VSYNC:  if (last) state_n = VBACK;
            VBACK:  if (last) state_n = HBLANK;
            HBLANK: if (last) state_n = ACTIVE;
            ACTIVE: if (last) begin
                line_n  = line + 16'd1;
                state_n = line == L_LINE ? VFRONT : HBLANK;
            end
            VFRONT: if (last) begin
                state_n = run ? VSYNC : IDLE;
                start   = run;
            end
            default: state_n = IDLE;
        endcase
        if (start) line_n = '0;
        act   = state_n == ACTIVE;
        phase = BPP == 2 && tcnt_n[0];
        adv   = act && (BPP == 1 || tcnt_n[0]);
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            tcnt        <= '0;
            line        <= '0;
            cmos_vsyn   <= 1'b0;
            cmos_href   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            line        <= line_n;
            cmos_vsyn   <= state_n == VSYNC;
            cmos_href   <= act;
            frame_start <= start;
            busy        <= state_n != IDLE;
            if (start) frame_cnt <= frame_cnt + 16'd1;
        end
    end
    cmos_pix_src #(.H_ACTIVE(H_ACTIVE), .BPP(BPP), .CNT_WRAP(CNT_WRAP)) u_pix (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .clr       (start),
        .act       (act),
        .phase     (phase),
        .adv       (adv),
        .mode      (mode),
        .const_pix (const_pix),
        .frame_cnt (frame_cnt),
        .data      (cmos_data)
    );
endmodule
